// File: rtl/reg18_ce2_fifo_rd.sv
// 18-bit FIFO. A word is written only when both clock enables are high.
// Reads are registered: out/out_valid update on the edge after rd_en_i.
module reg18_ce2_fifo_rd #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic [17:0]   in_i,
  input  logic          clk_en1_i,
  input  logic          clk_en2_i,
  input  logic          rd_en_i,
  output logic [17:0]   out_o,
  output logic          out_valid_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [AW:0]   count_o,
  output logic          overflow_o,
  output logic          underflow_o
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [17:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [17:0]   out_q, out_d;
  logic          out_valid_q, out_valid_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  logic is_empty, is_full, wreq, rd_acc, wr_acc;

  // Flags come only from the registered count, never from the inputs.
  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == FULL_CNT);
  assign wreq     = clk_en1_i & clk_en2_i;
  assign rd_acc   = rd_en_i & ~is_empty;
  // A read in the same cycle frees a slot, so a full FIFO may still accept.
  assign wr_acc   = wreq & (~is_full | rd_acc);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    ovf_d       = ovf_q;
    udf_d       = udf_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) begin
      rd_ptr_d    = rd_ptr_q + AW'(1);
      out_d       = mem_q[rd_ptr_q];
      out_valid_d = 1'b1;
    end
    if (wr_acc && !rd_acc)      count_d = count_q + (AW+1)'(1);
    else if (rd_acc && !wr_acc) count_d = count_q - (AW+1)'(1);
    if (wreq && !wr_acc)        ovf_d = 1'b1;
    if (rd_en_i && is_empty)    udf_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
    end
  end

  // Storage is not reset; contents are meaningless until written.
  always_ff @(posedge clk_i) begin
    if (!reset_i && wr_acc) mem_q[wr_ptr_q] <= in_i;
  end

  assign out_o       = out_q;
  assign out_valid_o = out_valid_q;
  assign empty_o     = is_empty;
  assign full_o      = is_full;
  assign count_o     = count_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = udf_q;

endmodule

// File: tb/tb_reg18_ce2_fifo_rd.sv
// Directed plus random stimulus for reg18_ce2_fifo_rd, checked against a
// queue-based reference model.
module tb_reg18_ce2_fifo_rd;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [17:0] in_d = '0;
  logic        en1 = 1'b0, en2 = 1'b0, rd = 1'b0;
  logic [17:0] out;
  logic        out_valid, empty, full, overflow, underflow;
  logic [AW:0] count;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  logic [17:0] q[$];
  logic [17:0] m_out;
  logic        m_vld, m_ovf, m_udf;

  reg18_ce2_fifo_rd #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_i(clk), .reset_i(reset), .in_i(in_d),
    .clk_en1_i(en1), .clk_en2_i(en2), .rd_en_i(rd),
    .out_o(out), .out_valid_o(out_valid), .empty_o(empty), .full_o(full),
    .count_o(count), .overflow_o(overflow), .underflow_o(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".out"},       32'(out),       32'(m_out));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_vld));
    chk({tag, ".count"},     32'(count),     32'(q.size()));
    chk({tag, ".empty"},     32'(empty),     32'(q.size() == 0));
    chk({tag, ".full"},      32'(full),      32'(q.size() == DEPTH));
    chk({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
    chk({tag, ".underflow"}, 32'(underflow), 32'(m_udf));
  endtask

  // One clock of stimulus; model applies the FIFO rules, then outputs are compared.
  task automatic step(input logic [17:0] d, input logic e1, input logic e2,
                      input logic r, input string tag);
    logic wreq, rd_ok, wr_ok;
    @(negedge clk);
    in_d = d; en1 = e1; en2 = e2; rd = r;
    @(posedge clk);
    wreq  = e1 & e2;
    rd_ok = r && (q.size() > 0);
    wr_ok = wreq && ((q.size() < DEPTH) || rd_ok);
    m_vld = 1'b0;
    if (rd_ok) begin m_out = q.pop_front(); m_vld = 1'b1; end
    if (r && !rd_ok) m_udf = 1'b1;
    if (wr_ok) q.push_back(d);
    else if (wreq) m_ovf = 1'b1;
    #1 chk_all(tag);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset = 1'b1; en1 = 1'b1; en2 = 1'b1; in_d = 18'h3FFFF; rd = 1'b0;
    repeat (cycles) @(posedge clk);
    q.delete(); m_out = '0; m_vld = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    #1 chk_all("reset");
    @(negedge clk);
    reset = 1'b0; en1 = 1'b0; en2 = 1'b0; in_d = '0;
  endtask

  initial begin
    m_out = '0; m_vld = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;

    do_reset(2);
    step('0, 0, 0, 0, "idle_after_reset");

    // enable qualification
    step(18'h00001, 1, 0, 0, "en_half");
    step(18'h00002, 1, 1, 0, "en_both");
    chk("en.count_is_1", 32'(count), 32'd1);
    step('0, 0, 0, 1, "en_read");
    chk("en.out_2", 32'(out), 32'h00002);
    step('0, 0, 0, 0, "en_valid_drop");
    chk("en.valid_one_cycle", 32'(out_valid), 32'd0);

    // fill and overflow
    for (int i = 0; i < 5; i++) step(18'h10000 + 18'(i), 1, 1, 0, "fill");
    chk("fill.overflow", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step('0, 0, 0, 1, "drain");
      chk("drain.order", 32'(out), 32'h10000 + 32'(i));
    end
    chk("drain.empty", 32'(empty), 32'd1);

    // simultaneous read/write while full (overflow already sticky, so reset first)
    do_reset(1);
    for (int i = 0; i < 4; i++) step(18'h20000 + 18'(i), 1, 1, 0, "refill");
    step(18'h2AAAA, 1, 1, 1, "full_rw");
    chk("full_rw.count", 32'(count), 32'd4);
    chk("full_rw.no_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) step('0, 0, 0, 1, "full_rw_drain");
    chk("full_rw.last", 32'(out), 32'h2AAAA);

    // simultaneous read/write while empty
    step(18'h0BEEF, 1, 1, 1, "empty_rw");
    chk("empty_rw.count", 32'(count), 32'd1);
    chk("empty_rw.udf", 32'(underflow), 32'd1);

    // wrap-around with one word resident
    do_reset(1);
    step(18'h000FF, 1, 1, 0, "wrap_pre");
    for (int i = 0; i < 10; i++) begin
      step(18'h00100 + 18'(i), 1, 1, 1, "wrap");
      chk("wrap.count", 32'(count), 32'd1);
    end

    // reset mid-operation
    do_reset(1);
    for (int i = 0; i < 3; i++) step(18'h30000 + 18'(i), 1, 1, 0, "pre_rst");
    do_reset(1);
    step(18'h01234, 1, 1, 0, "post_rst_wr");
    step('0, 0, 0, 1, "post_rst_rd");
    chk("post_rst.new_word", 32'(out), 32'h01234);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset(1);
      else step(18'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 2) == 0), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
